// File: rtl/led_frame_composer.sv
// Double-buffered LED bar frame composer for the tlc5920 driver: shadow rows are written over a
// valid/ready port and swapped to the active frame at a frame boundary. Option: LED_FRAME_TEST_PATTERN_EN.
module led_frame_composer #(
    parameter int g_rows      = 4,
    parameter int g_cols      = 16,
    parameter int g_blink_div = 50_000_000,
    parameter int g_swap_tmo  = 2_000_000
) (
    input  logic                                        Clk_ik,
`ifdef LED_FRAME_TEST_PATTERN_EN
    input  logic                                        TestMode_i,
`endif
    input  logic                                        Reset_irn,
    input  logic                                        WrValid_i,
    output logic                                        WrReady_o,
    input  logic [((g_rows > 1) ? $clog2(g_rows) : 1)-1:0] WrRow_ib,
    input  logic [2*g_cols-1:0]                         WrData_ib,
    input  logic                                        WrCommit_i,
    input  logic                                        FrameSync_i,
    output logic [g_rows-1:0][1:0][g_cols-1:0]          ledData_ob,
    output logic                                        Pending_o,
    output logic                                        SyncLost_o,
    output logic                                        RowErr_o,
    output logic [15:0]                                 SwapCnt_ob16
);

    localparam int BW = $clog2(g_blink_div);
    localparam int TW = $clog2(g_swap_tmo);
    localparam logic [BW-1:0] BLINK_LAST = BW'(g_blink_div - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(g_swap_tmo - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_SWAP} state_t;

    state_t                              state_q, state_d;
    logic [g_rows-1:0][2*g_cols-1:0]     shadow_q, shadow_d;
    logic [g_rows-1:0][2*g_cols-1:0]     active_q, active_d;
    logic [g_rows-1:0][1:0][g_cols-1:0]  led_q, led_d;
    logic [15:0]                         swap_cnt_q, swap_cnt_d;
    logic [TW-1:0]                       timer_q, timer_d;
    logic [BW-1:0]                       blink_cnt_q, blink_cnt_d;
    logic                                phase_q, phase_d;
    logic                                wr_ready_q, wr_ready_d;
    logic                                sync_lost_q, sync_lost_d;
    logic                                row_err_q, row_err_d;
    logic                                accept;
    logic [1:0]                          code;

`ifdef LED_FRAME_TEST_PATTERN_EN
    localparam int PW = (g_rows * g_cols > 1) ? $clog2(g_rows * g_cols) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(g_rows * g_cols - 1);
    logic [PW-1:0] pos_q, pos_d;
    logic          tm_q, tm_d;
`endif

    // wr_ready_q is only ever high in IDLE, so it alone qualifies a beat
    assign accept = WrValid_i && wr_ready_q;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        swap_cnt_d  = swap_cnt_q;
        timer_d     = timer_q;
        sync_lost_d = sync_lost_q;
        row_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (int'(WrRow_ib) < g_rows) begin
                        shadow_d[WrRow_ib] = WrData_ib;
                    end else begin
                        row_err_d = 1'b1;
                    end
                    if (WrCommit_i) begin
                        state_d = ST_PENDING;
                        timer_d = '0;
                    end
                end
            end
            ST_PENDING: begin
                if (FrameSync_i) begin
                    state_d     = ST_SWAP;
                    sync_lost_d = 1'b0;
                end else if (timer_q == TMO_LAST) begin
                    state_d     = ST_SWAP;
                    sync_lost_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SWAP: begin
                active_d   = shadow_q;
                swap_cnt_d = swap_cnt_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ready_d = (state_d == ST_IDLE);
    end

    // Blink timebase runs freely, independent of swaps
    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

`ifdef LED_FRAME_TEST_PATTERN_EN
    always_comb begin
        tm_d  = TestMode_i;
        pos_d = pos_q;
        if (TestMode_i && !tm_q) begin
            pos_d = '0;
        end else if (TestMode_i && FrameSync_i) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        end
    end
`endif

    always_comb begin
        led_d = '0;
        code  = 2'b00;
        for (int r = 0; r < g_rows; r++) begin
            for (int c = 0; c < g_cols; c++) begin
                code           = active_q[r][2*c +: 2];
                led_d[r][0][c] = (code == 2'b01);
                led_d[r][1][c] = (code == 2'b10) || ((code == 2'b11) && phase_q);
            end
        end
`ifdef LED_FRAME_TEST_PATTERN_EN
        if (TestMode_i) begin
            led_d = '0;
            for (int r = 0; r < g_rows; r++) begin
                for (int c = 0; c < g_cols; c++) begin
                    led_d[r][1][c] = ((r * g_cols + c) == int'(pos_d));
                end
            end
        end
`endif
    end

    always_ff @(posedge Clk_ik) begin
        if (!Reset_irn) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            led_q       <= '0;
            swap_cnt_q  <= '0;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
            sync_lost_q <= 1'b0;
            row_err_q   <= 1'b0;
`ifdef LED_FRAME_TEST_PATTERN_EN
            pos_q       <= '0;
            tm_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            led_q       <= led_d;
            swap_cnt_q  <= swap_cnt_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            wr_ready_q  <= wr_ready_d;
            sync_lost_q <= sync_lost_d;
            row_err_q   <= row_err_d;
`ifdef LED_FRAME_TEST_PATTERN_EN
            pos_q       <= pos_d;
            tm_q        <= tm_d;
`endif
        end
    end

    assign WrReady_o    = wr_ready_q;
    assign Pending_o    = (state_q == ST_PENDING);
    assign SyncLost_o   = sync_lost_q;
    assign RowErr_o     = row_err_q;
    assign SwapCnt_ob16 = swap_cnt_q;
    assign ledData_ob   = led_q;

endmodule
